// File: rtl/dram_pkg.sv
// Shared types and constants for the dram read port and its arbiters.
package dram_pkg;

  localparam int ROW_W  = 4;
  localparam int DATA_W = 32;

  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Index width for a client vector; never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dram_rd_arbiter_if.sv
// Client request/response bundle plus the dram read port.
// slave  = arbiter view, master = client/dram side view.
interface dram_rd_arbiter_if
  import dram_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*ROW_W-1:0] row_in;
  logic [NREQ-1:0]       ack;
  data_t                 rd_data;
  logic                  rd_err;
  logic                  busy;
  logic                  mem_req;
  row_t                  mem_row;
  logic                  mem_valid;
  data_t                 mem_data;

  modport slave (
    input  req, row_in, mem_valid, mem_data,
    output ack, rd_data, rd_err, busy, mem_req, mem_row
  );

  modport master (
    output req, row_in, mem_valid, mem_data,
    input  ack, rd_data, rd_err, busy, mem_req, mem_row
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NREQ (explicit wrap, so NREQ need not be a power of two).
module rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = dram_pkg::idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [NREQ-1:0] req_rot;
  logic [IDX_W-1:0] ofs;
  logic [IDX_W:0]   sum;

  // Rotate so rr_ptr lands at bit 0, find the lowest set bit, rotate back.
  always_comb begin
    req_rot = NREQ'({req, req} >> rr_ptr);
    valid   = |req_rot;
    ofs     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) ofs = IDX_W'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, ofs};
    if (sum >= (IDX_W + 1)'(NREQ)) sum = sum - (IDX_W + 1)'(NREQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Round-robin read arbiter/sequencer for the shared dram read port.
// One read in flight at a time; data returned with a one-cycle ack,
// unanswered reads end with rd_err after TIMEOUT.
// Optional build macro DRAM_REFRESH_EN adds periodic refresh reads that
// take priority at the next IDLE decision.
//
// state | meaning
// IDLE  | no read in flight, choosing the next requester
// ISSUE | mem_req strobe for the latched row, timer cleared
// WAIT  | waiting for mem_valid or timer == TIMEOUT
// RESP  | ack/rd_data/rd_err presented, rr_ptr advanced
module dram_rd_arbiter
  import dram_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
`ifdef DRAM_REFRESH_EN
  , parameter int REFRESH_PERIOD = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  dram_rd_arbiter_if.slave bus
);

  localparam int         IDX_W      = idx_width(NREQ);
  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       timer_q, timer_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  data_t            rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;
  logic             busy_q, busy_d;
  logic             mem_req_q, mem_req_d;
  row_t             mem_row_q, mem_row_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  row_t             pick_row;
  logic             client_txn;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Row address of the client the picker selected.
  always_comb begin
    pick_row = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_row = bus.row_in[i*ROW_W +: ROW_W];
    end
  end

`ifdef DRAM_REFRESH_EN
  logic [15:0] ref_cnt_q, ref_cnt_d;
  logic        ref_expire;
  logic        ref_pend_q, ref_pend_d;
  logic        is_ref_q, is_ref_d;
  row_t        ref_row_q, ref_row_d;

  // Free-running refresh down-counter; terminal count raises a pending refresh.
  always_comb begin
    ref_expire = (ref_cnt_q == 16'd0);
    ref_cnt_d  = ref_expire ? 16'(REFRESH_PERIOD - 1) : ref_cnt_q - 16'd1;
  end

  assign client_txn = !is_ref_q;
`else
  assign client_txn = 1'b1;
`endif

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    ack_d     = '0;
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    mem_req_d = 1'b0;
    mem_row_d = mem_row_q;
`ifdef DRAM_REFRESH_EN
    is_ref_d   = is_ref_q;
    ref_row_d  = ref_row_q;
    ref_pend_d = ref_pend_q | ref_expire;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef DRAM_REFRESH_EN
        if (ref_pend_q) begin
          state_d    = ISSUE;
          is_ref_d   = 1'b1;
          mem_row_d  = ref_row_q;
          mem_req_d  = 1'b1;
          ref_pend_d = ref_expire;
        end else
`endif
        if (pick_valid) begin
          state_d   = ISSUE;
          idx_d     = pick_idx;
          mem_row_d = pick_row;
          mem_req_d = 1'b1;
`ifdef DRAM_REFRESH_EN
          is_ref_d  = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        if (bus.mem_valid || timer_q == TIMEOUT_TC) begin
          state_d = RESP;
          if (client_txn) begin
            ack_d[idx_q] = 1'b1;
            rd_err_d     = !bus.mem_valid;
            rd_data_d    = bus.mem_valid ? bus.mem_data : '0;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (client_txn) begin
          rr_ptr_d = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        end
`ifdef DRAM_REFRESH_EN
        else begin
          ref_row_d = ref_row_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      ack_q     <= '0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      busy_q    <= 1'b0;
      mem_req_q <= 1'b0;
      mem_row_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
      busy_q    <= busy_d;
      mem_req_q <= mem_req_d;
      mem_row_q <= mem_row_d;
    end
  end

`ifdef DRAM_REFRESH_EN
  // Refresh bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q  <= 16'(REFRESH_PERIOD - 1);
      ref_pend_q <= 1'b0;
      is_ref_q   <= 1'b0;
      ref_row_q  <= '0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      is_ref_q   <= is_ref_d;
      ref_row_q  <= ref_row_d;
    end
  end
`endif

  assign bus.ack     = ack_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_err  = rd_err_q;
  assign bus.busy    = busy_q;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_row = mem_row_q;

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Self-checking bench for dram_rd_arbiter: randomized clients and dram
// latency against a transaction-level round-robin reference model.
module tb_dram_rd_arbiter;
  import dram_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_rd_arbiter_if #(.NREQ(NREQ)) bus ();

  dram_rd_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [NREQ-1:0] ack;
    data_t           data;
    logic            err;
    int              cyc;
  } ack_rec_t;

  typedef struct {
    int row;
    int cyc;
  } iss_rec_t;

  int       checks   = 0;
  int       failures = 0;
  data_t    dmem[16];
  int       rows[NREQ];
  int       model_ptr = 0;
  int       dram_lat  = 1;
  bit       stray     = 1'b0;
  int       cyc       = 0;
  int       pend      = 0;
  row_t     prow;
  ack_rec_t ack_q[$];
  iss_rec_t iss_q[$];

  // Monitor: log every ack pulse and every mem_req strobe with its cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (bus.ack !== '0) ack_q.push_back('{bus.ack, bus.rd_data, bus.rd_err, cyc});
      if (bus.mem_req === 1'b1) iss_q.push_back('{int'(bus.mem_row), cyc});
    end
  end

  // Dram model: answers a strobe after dram_lat cycles (0 = never answers).
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_valid = stray;
      bus.mem_data  = stray ? data_t'($urandom) : '0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend = pend - 1;
          if (pend == 0) begin
            bus.mem_valid = 1'b1;
            bus.mem_data  = dmem[prow];
          end
        end
        if (bus.mem_req === 1'b1 && dram_lat > 0) begin
          pend = dram_lat;
          prow = bus.mem_row;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arbitration: first requester at or after ptr, modulo NREQ.
  function automatic int rr_next(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (p + k) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_rows();
    for (int i = 0; i < NREQ; i++) bus.row_in[i*ROW_W +: ROW_W] = row_t'(rows[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_ptr = 0;
    ack_q.delete();
    iss_q.delete();
  endtask

  // Drive a client mask, collect n_txn acks and check each against the model.
  task automatic run_clients(input logic [NREQ-1:0] mask, input bit hold, input int n_txn,
                             input int lat, input string name);
    logic [NREQ-1:0] cur;
    logic [NREQ-1:0] exp_ack;
    ack_rec_t ar;
    iss_rec_t ir;
    int done, budget, exp, exp_diff;
    bit ok;
    data_t exp_data;
    done = 0;
    budget = n_txn * (TIMEOUT + 10) + 20;
    dram_lat = lat;
    ok = (lat >= 1 && lat <= TIMEOUT + 1);
    exp_diff = ok ? lat + 1 : TIMEOUT + 2;
    set_rows();
    cur = mask;
    bus.req = cur;
    while (done < n_txn && budget > 0) begin
      @(negedge clk);
      #1;
      budget = budget - 1;
      if (ack_q.size() > 0) begin
        ar = ack_q.pop_front();
        exp = rr_next(cur, model_ptr);
        exp_ack = NREQ'(1) << exp;
        exp_data = ok ? dmem[rows[exp]] : '0;
        checks++;
        if (ar.ack !== exp_ack) begin
          failures++;
          $display("FAIL %s ack: got=%b want=%b", name, ar.ack, exp_ack);
        end
        checks++;
        if (ar.data !== exp_data) begin
          failures++;
          $display("FAIL %s rd_data: got=%h want=%h", name, ar.data, exp_data);
        end
        checks++;
        if (ar.err !== !ok) begin
          failures++;
          $display("FAIL %s rd_err: got=%b want=%b", name, ar.err, !ok);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_in_resp: got=%b want=1", name, bus.busy);
        end
        checks++;
        if (iss_q.size() != 1) begin
          failures++;
          $display("FAIL %s strobes_per_txn: got=%0d want=1", name, iss_q.size());
          iss_q.delete();
        end else begin
          ir = iss_q.pop_front();
          checks++;
          if (ir.row != rows[exp]) begin
            failures++;
            $display("FAIL %s mem_row: got=%0d want=%0d", name, ir.row, rows[exp]);
          end
          checks++;
          if (ar.cyc - ir.cyc != exp_diff) begin
            failures++;
            $display("FAIL %s strobe_to_ack: got=%0d want=%0d", name, ar.cyc - ir.cyc, exp_diff);
          end
        end
        model_ptr = (exp + 1) % NREQ;
        if (!hold) cur[exp] = 1'b0;
        if (hold && done == n_txn - 1) cur = '0;
        bus.req = cur;
        done++;
      end
    end
    checks++;
    if (done != n_txn) begin
      failures++;
      $display("FAIL %s completed: got=%0d want=%0d", name, done, n_txn);
    end
    bus.req = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || ack_q.size() != 0 || iss_q.size() != 0) begin
      failures++;
      $display("FAIL %s back_to_idle: busy=%b acks=%0d strobes=%0d want 0/0/0",
               name, bus.busy, ack_q.size(), iss_q.size());
      ack_q.delete();
      iss_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.ack !== '0)     begin failures++; $display("FAIL reset ack: got=%b want=0", bus.ack); end
    checks++; if (bus.rd_data !== '0) begin failures++; $display("FAIL reset rd_data: got=%h want=0", bus.rd_data); end
    checks++; if (bus.rd_err !== 1'b0) begin failures++; $display("FAIL reset rd_err: got=%b want=0", bus.rd_err); end
    checks++; if (bus.busy !== 1'b0)  begin failures++; $display("FAIL reset busy: got=%b want=0", bus.busy); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset mem_req: got=%b want=0", bus.mem_req); end
    checks++; if (bus.mem_row !== '0) begin failures++; $display("FAIL reset mem_row: got=%h want=0", bus.mem_row); end
  endtask

  task automatic test_single();
    rows[0] = 0;
    run_clients(4'b0001, 1'b0, 1, 1, "single");
  endtask

  task automatic test_contention();
    do_reset();
    rows[0] = 14; rows[1] = 12; rows[2] = 2; rows[3] = 3;
    run_clients(4'b1111, 1'b0, 4, $urandom_range(1, 3), "contention");
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] m;
    rows[0] = $urandom_range(0, 15);
    rows[2] = $urandom_range(0, 15);
    run_clients(4'b0101, 1'b1, 8, 1, "fairness");
    m = NREQ'($urandom_range(0, 15)) | 4'b1001;
    for (int i = 0; i < NREQ; i++) rows[i] = $urandom_range(0, 15);
    run_clients(m, 1'b1, 7, $urandom_range(1, 4), "fair_rand");
  endtask

  task automatic test_timeout();
    rows[3] = 9;
    run_clients(4'b1000, 1'b0, 1, 0, "timeout");
    run_clients(4'b1000, 1'b0, 1, TIMEOUT + 1, "lat_max");
    run_clients(4'b1000, 1'b0, 1, TIMEOUT + 2, "lat_late");
  endtask

  task automatic test_stray_valid();
    bus.req = '0;
    stray = 1'b1;
    repeat (4) @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ack_q.size() != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_valid: acks=%0d busy=%b want 0/0", ack_q.size(), bus.busy);
      ack_q.delete();
    end
  endtask

  task automatic test_drop_mid();
    ack_rec_t ar;
    int exp, budget;
    rows[3] = $urandom_range(0, 15);
    set_rows();
    dram_lat = 3;
    bus.req = 4'b1000;
    budget = 10;
    while (iss_q.size() == 0 && budget > 0) begin @(negedge clk); #1; budget--; end
    bus.req = '0;
    bus.row_in[3*ROW_W +: ROW_W] = ~row_t'(rows[3]);
    budget = 10;
    while (ack_q.size() == 0 && budget > 0) begin @(negedge clk); #1; budget--; end
    exp = rr_next(4'b1000, model_ptr);
    checks++;
    if (ack_q.size() != 1 || iss_q.size() != 1) begin
      failures++;
      $display("FAIL drop_mid acks/strobes: got=%0d/%0d want=1/1", ack_q.size(), iss_q.size());
    end else begin
      ar = ack_q.pop_front();
      checks++;
      if (ar.ack !== 4'b1000 || ar.data !== dmem[rows[3]] || ar.err !== 1'b0) begin
        failures++;
        $display("FAIL drop_mid resp: ack=%b data=%h err=%b want 1000/%h/0",
                 ar.ack, ar.data, ar.err, dmem[rows[3]]);
      end
      checks++;
      if (iss_q[0].row != rows[3]) begin
        failures++;
        $display("FAIL drop_mid mem_row: got=%0d want=%0d", iss_q[0].row, rows[3]);
      end
    end
    model_ptr = (exp + 1) % NREQ;
    ack_q.delete();
    iss_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int budget;
    rows[2] = $urandom_range(1, 15);
    set_rows();
    dram_lat = 0;
    bus.req = 4'b0100;
    budget = 10;
    while (iss_q.size() == 0 && budget > 0) begin @(negedge clk); #1; budget--; end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_row !== row_t'(rows[2])) begin
      failures++;
      $display("FAIL rst_mid in_wait: busy=%b mem_req=%b mem_row=%0d want 1/0/%0d",
               bus.busy, bus.mem_req, bus.mem_row, rows[2]);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy: got=%b want=0", bus.busy); end
    checks++; if (bus.mem_row !== '0) begin failures++; $display("FAIL rst_mid mem_row: got=%0d want=0", bus.mem_row); end
    checks++; if (bus.ack !== '0 || bus.mem_req !== 1'b0) begin
      failures++; $display("FAIL rst_mid ack/mem_req: got=%b/%b want=0/0", bus.ack, bus.mem_req); end
    #2;
    rst_n = 1'b1;
    bus.req = '0;
    model_ptr = 0;
    ack_q.delete();
    iss_q.delete();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (ack_q.size() != 0 || iss_q.size() != 0) begin
      failures++;
      $display("FAIL rst_mid no_ack: acks=%0d strobes=%0d want 0/0", ack_q.size(), iss_q.size());
      ack_q.delete();
      iss_q.delete();
    end
    rows[1] = $urandom_range(0, 15);
    run_clients(4'b0010, 1'b0, 1, 2, "after_rst");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] m;
    int lat;
    for (int it = 0; it < 8; it++) begin
      m = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) rows[i] = $urandom_range(0, 15);
      lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4);
      run_clients(m, 1'b0, $countones(m), lat, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = data_t'($urandom);
    for (int i = 0; i < NREQ; i++) rows[i] = 0;
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.row_in = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_stray_valid();
    test_drop_mid();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_rd_arbiter.md
Name: dram_rd_arbiter

Overview:
Round-robin read arbiter and sequencer for the shared 16x32 dram read port (1-bit strobe, 4-bit row, valid + 32-bit data return). It accepts row-read requests from NREQ clients and issues one dram read at a time. It returns the data to the granting client with a one-cycle ack, and flags reads the dram never answers. It sits between the dram instance and the client logic.

Parameters:
NREQ, 4, number of requesting clients (2..8)
ROW_W, 4, dram row address width
DATA_W, 32, dram row data width
TIMEOUT, 15, max cycles in WAIT before the read is aborted with error (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-client read request, level, held until ack
row_in  in  NREQ*ROW_W  per-client row address; client i uses bits [i*ROW_W +: ROW_W]
ack  out  NREQ  one-hot, one-cycle pulse: read for that client complete
rd_data  out  DATA_W  returned row data, valid only in the ack cycle
rd_err  out  1  qualifies ack: read timed out, rd_data = 0
busy  out  1  high while state != IDLE
mem_req  out  1  one-cycle read strobe to dram
mem_row  out  ROW_W  row to dram, held stable from ISSUE through WAIT
mem_valid  in  1  dram output-valid
mem_data  in  DATA_W  dram row data

Behaviour:
- Reset (async assert, sync release): state=IDLE; rr_ptr=0; ack=0; rd_data=0; rd_err=0; busy=0; mem_req=0; mem_row=0; timer=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick the first set bit at or after rr_ptr, wrapping modulo NREQ. Latch its index and row. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): mem_req=1 and mem_row=latched row; timer cleared. Next state WAIT.
- WAIT: mem_req=0.
  - If mem_valid: capture mem_data, go to RESP.
  - Else if timer == TIMEOUT: set the error flag, go to RESP.
  - Else timer+1.
- RESP (1 cycle): ack[idx]=1; rd_data = captured data (0 on error); rd_err = flag. rr_ptr = (idx+1) mod NREQ. Next state IDLE.
- Throughput: 1 request per (3 + dram latency) cycles. Minimum request-to-ack is 4 cycles with a 1-cycle dram.
- The latched row and index ignore later changes to row_in and req.
- If a client drops req mid-transaction, the transaction still completes and ack is still pulsed.
- mem_valid outside WAIT is ignored.
- After its ack, a client holding req continues to be eligible. Round-robin guarantees that every other requester is served before that client is served again.
- Reset asserted mid-transaction aborts the transaction immediately: no ack; mem_req drops asynchronously.
- NREQ not a power of two: the rr_ptr wrap is explicit (idx == NREQ-1 -> 0).

Optional Feature:
DRAM_REFRESH_EN
- Defined: adds parameter REFRESH_PERIOD (default 64) and a free-running counter.
  - When the counter expires, a refresh is pending. It has priority over clients at the next IDLE decision and never preempts a transaction in progress.
  - A refresh runs ISSUE/WAIT on refresh row ref_row; no ack is pulsed and rr_ptr is unchanged.
  - After the refresh, ref_row increments and wraps 15 -> 0.
  - busy is high during the refresh.
  - Timeout on a refresh is silent.
- Undefined: no refresh logic; behaviour exactly as above.

Decomposition:
- Package dram_pkg: ROW_W/DATA_W constants, state enum (IDLE, ISSUE, WAIT, RESP), and a row_t/data_t typedef.
- Sub-module rr_pick: combinational round-robin priority picker. Inputs req and rr_ptr; outputs a valid flag and the index. Reused by future write arbiter.

Test Plan:
- Single request: req=4'b0001, row 0 → mem_req pulses once with mem_row=0. ack=4'b0001 one cycle after mem_valid; rd_data = dram row 0; rd_err=0.
- Contention: all four req high, rows 14, 12, 2, 3; rr_ptr=0 → grants in order 0, 1, 2, 3. Each ack carries its own row's data; no overlapping mem_req.
- Fairness: clients 0 and 2 both hold req continuously → acks alternate 0, 2, 0, 2 over 8 transactions.
- Timeout: dram model never raises mem_valid; req=4'b1000, row 9 → ack[3] with rd_err=1 and rd_data=0, exactly TIMEOUT+1 cycles after leaving ISSUE. Then IDLE.
- Reset mid-WAIT: assert rst_n=0 for 3 ns during WAIT → all outputs 0 immediately, no ack. Next request after release is served normally.
- DRAM_REFRESH_EN with REFRESH_PERIOD=16 and a steady client 1 → refresh strobes on rows 0, 1, 2 … interleaved between client reads. Client acks are never lost.
